rv_fetch_bridge: RTL and testbench

RV_FETCH_BRIDGE -- requirements
Module: rv_fetch_bridge

---
 rtl/rv_fetch_bridge.sv | 111 +++++++++++
 tb/tb_rv_fetch_bridge.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_bridge.sv
`timescale 1ns/1ps
// Instruction fetch bridge: a one-word buffer in front of a request/grant memory port.
// Hits are served combinationally; misses run a REQ/WAIT handshake guarded by a timeout.
module rv_fetch_bridge #(
  parameter logic [31:0] NOP_INST = 32'h00000013,
  parameter int          MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_addr_i,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t             state;
  logic [31:2]        buf_tag;
  logic [31:0]        buf_data;
  logic               buf_valid;
  logic [31:0]        req_addr;
  logic               drop;
  logic [CNT_W-1:0]   wait_cnt;
  logic               hit;
  logic               timeout;

  assign hit          = buf_valid && (inst_addr_i[31:2] == buf_tag) && (state == IDLE);
  // A response arriving in the last allowed cycle still counts; only silence times out.
  assign timeout      = (state != IDLE) && (wait_cnt == LAST_CNT)
                        && !((state == WAIT) && mem_rvalid_i);

  assign inst_o       = hit ? buf_data : NOP_INST;
  assign inst_valid_o = hit;
  assign stall_o      = !hit;
  assign misaligned_o = (inst_addr_i[1:0] != 2'b00);
  assign mem_req_o    = (state == REQ);
  assign mem_addr_o   = req_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      buf_tag   <= '0;
      buf_data  <= '0;
      buf_valid <= 1'b0;
      req_addr  <= '0;
      drop      <= 1'b0;
      wait_cnt  <= '0;
      err_o     <= 1'b0;
    end else begin
      if (flush_i)
        buf_valid <= 1'b0;
      if ((state != IDLE) && (wait_cnt != '1))
        wait_cnt <= wait_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (!hit && !flush_i) begin
            req_addr <= {inst_addr_i[31:2], 2'b00};
            wait_cnt <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (flush_i)
            drop <= 1'b1;
          // Timeout wins over a late grant so the request is withdrawn cleanly.
          if (timeout) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            err_o     <= 1'b1;
            drop      <= 1'b0;
          end else if (mem_gnt_i) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (flush_i)
            drop <= 1'b1;
          if (mem_rvalid_i) begin
            if (!drop && !flush_i) begin
              buf_data  <= mem_rdata_i;
              buf_tag   <= req_addr[31:2];
              buf_valid <= 1'b1;
            end
            drop  <= 1'b0;
            state <= IDLE;
          end else if (timeout) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            err_o     <= 1'b1;
            drop      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_fetch_bridge.sv
`timescale 1ns/1ps
// Directed bench for rv_fetch_bridge: memory side is driven by hand, one task per scenario.
module tb_rv_fetch_bridge;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_addr_i;
  logic        flush_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stall_o;
  logic        misaligned_o;
  logic        err_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int compared   = 0;
  int mismatches = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  rv_fetch_bridge #(.NOP_INST(32'h00000013), .MAX_WAIT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_addr_i  (inst_addr_i),
    .flush_i      (flush_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .stall_o      (stall_o),
    .misaligned_o (misaligned_o),
    .err_o        (err_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge; inputs are then changed and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inst_addr_i = 32'h0; flush_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    #3;
    compared++; if (mem_req_o !== 1'b0) begin mismatches++; $display("[TB] FAIL reset_req: got %b expected 0", mem_req_o); end
    compared++; if (mem_addr_o !== 32'h0) begin mismatches++; $display("[TB] FAIL reset_addr: got %h expected 00000000", mem_addr_o); end
    compared++; if (inst_o !== NOP) begin mismatches++; $display("[TB] FAIL reset_inst: got %h expected %h", inst_o, NOP); end
    compared++; if (inst_valid_o !== 1'b0) begin mismatches++; $display("[TB] FAIL reset_valid: got %b expected 0", inst_valid_o); end
    compared++; if (stall_o !== 1'b1) begin mismatches++; $display("[TB] FAIL reset_stall: got %b expected 1", stall_o); end
    compared++; if (err_o !== 1'b0) begin mismatches++; $display("[TB] FAIL reset_err: got %b expected 0", err_o); end
    repeat (2) tick();
  endtask

  // Address 0, grant immediately, data the cycle after: three stall cycles then a hit.
  task automatic test_basic_fetch();
    tick();
    rst_n = 1'b1;
    #1;
    compared++; if (stall_o !== 1'b1) begin mismatches++; $display("[TB] FAIL basic_stall_n: got %b expected 1", stall_o); end
    compared++; if (mem_req_o !== 1'b0) begin mismatches++; $display("[TB] FAIL basic_req_n: got %b expected 0", mem_req_o); end
    compared++; if (misaligned_o !== 1'b0) begin mismatches++; $display("[TB] FAIL basic_misaligned: got %b expected 0", misaligned_o); end
    tick();
    mem_gnt_i = 1'b1;
    #1;
    compared++; if (mem_req_o !== 1'b1) begin mismatches++; $display("[TB] FAIL basic_req_n1: got %b expected 1", mem_req_o); end
    compared++; if (mem_addr_o !== 32'h0) begin mismatches++; $display("[TB] FAIL basic_addr_n1: got %h expected 00000000", mem_addr_o); end
    compared++; if (stall_o !== 1'b1) begin mismatches++; $display("[TB] FAIL basic_stall_n1: got %b expected 1", stall_o); end
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00500093;
    #1;
    compared++; if (mem_req_o !== 1'b0) begin mismatches++; $display("[TB] FAIL basic_req_n2: got %b expected 0", mem_req_o); end
    compared++; if (stall_o !== 1'b1) begin mismatches++; $display("[TB] FAIL basic_stall_n2: got %b expected 1", stall_o); end
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    compared++; if (inst_o !== 32'h00500093) begin mismatches++; $display("[TB] FAIL basic_inst: got %h expected 00500093", inst_o); end
    compared++; if (inst_valid_o !== 1'b1) begin mismatches++; $display("[TB] FAIL basic_valid: got %b expected 1", inst_valid_o); end
    compared++; if (stall_o !== 1'b0) begin mismatches++; $display("[TB] FAIL basic_stall_n3: got %b expected 0", stall_o); end
  endtask

  // Move to 0x4, grant withheld for 5 cycles while the core address wanders; request must hold.
  task automatic test_delayed_gnt();
    tick();
    inst_addr_i = 32'h4;
    #1;
    compared++; if (stall_o !== 1'b1) begin mismatches++; $display("[TB] FAIL dgnt_stall: got %b expected 1", stall_o); end
    compared++; if (inst_o !== NOP) begin mismatches++; $display("[TB] FAIL dgnt_nop: got %h expected %h", inst_o, NOP); end
    for (int i = 0; i < 5; i++) begin
      tick();
      inst_addr_i = (i >= 2) ? 32'h100 : 32'h4;
      #1;
      compared++; if (mem_req_o !== 1'b1) begin mismatches++; $display("[TB] FAIL dgnt_req[%0d]: got %b expected 1", i, mem_req_o); end
      compared++; if (mem_addr_o !== 32'h4) begin mismatches++; $display("[TB] FAIL dgnt_addr[%0d]: got %h expected 00000004", i, mem_addr_o); end
    end
    tick();
    inst_addr_i = 32'h4; mem_gnt_i = 1'b1;
    #1;
    compared++; if (mem_addr_o !== 32'h4) begin mismatches++; $display("[TB] FAIL dgnt_addr_gnt: got %h expected 00000004", mem_addr_o); end
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00A00113;
    #1;
    compared++; if (mem_req_o !== 1'b0) begin mismatches++; $display("[TB] FAIL dgnt_req_wait: got %b expected 0", mem_req_o); end
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    compared++; if (inst_o !== 32'h00A00113) begin mismatches++; $display("[TB] FAIL dgnt_inst: got %h expected 00a00113", inst_o); end
    compared++; if (inst_valid_o !== 1'b1) begin mismatches++; $display("[TB] FAIL dgnt_valid: got %b expected 1", inst_valid_o); end
  endtask

  // Flush during WAIT poisons the response; the same word is then fetched again.
  task automatic test_flush_wait();
    tick();
    inst_addr_i = 32'h8;
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    compared++; if (inst_valid_o !== 1'b0) begin mismatches++; $display("[TB] FAIL fwait_valid: got %b expected 0", inst_valid_o); end
    compared++; if (inst_o !== NOP) begin mismatches++; $display("[TB] FAIL fwait_inst: got %h expected %h", inst_o, NOP); end
    tick();
    mem_gnt_i = 1'b1;
    #1;
    compared++; if (mem_req_o !== 1'b1) begin mismatches++; $display("[TB] FAIL fwait_rereq: got %b expected 1", mem_req_o); end
    compared++; if (mem_addr_o !== 32'h8) begin mismatches++; $display("[TB] FAIL fwait_readdr: got %h expected 00000008", mem_addr_o); end
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00100073;
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    compared++; if (inst_o !== 32'h00100073) begin mismatches++; $display("[TB] FAIL fwait_inst2: got %h expected 00100073", inst_o); end
  endtask

  // Flush in IDLE suppresses the miss; flush coinciding with rvalid keeps the buffer invalid.
  task automatic test_flush_idle();
    tick();
    inst_addr_i = 32'hC; flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    compared++; if (mem_req_o !== 1'b0) begin mismatches++; $display("[TB] FAIL fidle_blocked: got %b expected 0", mem_req_o); end
    tick();
    mem_gnt_i = 1'b1;
    #1;
    compared++; if (mem_addr_o !== 32'hC) begin mismatches++; $display("[TB] FAIL fidle_addr: got %h expected 0000000c", mem_addr_o); end
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; flush_i = 1'b1; mem_rdata_i = 32'h11111111;
    tick();
    mem_rvalid_i = 1'b0; flush_i = 1'b0;
    #1;
    compared++; if (inst_valid_o !== 1'b0) begin mismatches++; $display("[TB] FAIL fsame_valid: got %b expected 0", inst_valid_o); end
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h22222222;
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    compared++; if (inst_o !== 32'h22222222) begin mismatches++; $display("[TB] FAIL fsame_inst: got %h expected 22222222", inst_o); end
  endtask

  // 16 silent cycles in REQ+WAIT set the sticky error; the retry then succeeds.
  task automatic test_timeout();
    tick();
    inst_addr_i = 32'h20;
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    repeat (14) tick();
    #1;
    compared++; if (err_o !== 1'b0) begin mismatches++; $display("[TB] FAIL tout_early: got %b expected 0", err_o); end
    tick();
    #1;
    compared++; if (err_o !== 1'b1) begin mismatches++; $display("[TB] FAIL tout_err: got %b expected 1", err_o); end
    compared++; if (mem_req_o !== 1'b0) begin mismatches++; $display("[TB] FAIL tout_idle: got %b expected 0", mem_req_o); end
    tick();
    mem_gnt_i = 1'b1;
    #1;
    compared++; if (mem_req_o !== 1'b1) begin mismatches++; $display("[TB] FAIL tout_retry: got %b expected 1", mem_req_o); end
    compared++; if (mem_addr_o !== 32'h20) begin mismatches++; $display("[TB] FAIL tout_retry_addr: got %h expected 00000020", mem_addr_o); end
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00300193;
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    compared++; if (inst_o !== 32'h00300193) begin mismatches++; $display("[TB] FAIL tout_inst: got %h expected 00300193", inst_o); end
    compared++; if (err_o !== 1'b1) begin mismatches++; $display("[TB] FAIL tout_sticky: got %b expected 1", err_o); end
  endtask

  task automatic test_misaligned();
    tick();
    inst_addr_i = 32'h6;
    #1;
    compared++; if (misaligned_o !== 1'b1) begin mismatches++; $display("[TB] FAIL mis_flag: got %b expected 1", misaligned_o); end
    tick();
    mem_gnt_i = 1'b1;
    #1;
    compared++; if (mem_addr_o !== 32'h4) begin mismatches++; $display("[TB] FAIL mis_addr: got %h expected 00000004", mem_addr_o); end
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h01234567;
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    compared++; if (inst_o !== 32'h01234567) begin mismatches++; $display("[TB] FAIL mis_inst: got %h expected 01234567", inst_o); end
  endtask

  // Reset during WAIT abandons the fetch; the stale rvalid after release must not fill the buffer.
  task automatic test_reset_mid();
    tick();
    inst_addr_i = 32'h40;
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; rst_n = 1'b0;
    #1;
    compared++; if (err_o !== 1'b0) begin mismatches++; $display("[TB] FAIL rmid_err: got %b expected 0", err_o); end
    compared++; if (mem_req_o !== 1'b0) begin mismatches++; $display("[TB] FAIL rmid_req: got %b expected 0", mem_req_o); end
    tick();
    rst_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55555555;
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    compared++; if (inst_valid_o !== 1'b0) begin mismatches++; $display("[TB] FAIL rmid_valid: got %b expected 0", inst_valid_o); end
    compared++; if (mem_req_o !== 1'b1) begin mismatches++; $display("[TB] FAIL rmid_rereq: got %b expected 1", mem_req_o); end
    compared++; if (mem_addr_o !== 32'h40) begin mismatches++; $display("[TB] FAIL rmid_addr: got %h expected 00000040", mem_addr_o); end
  endtask

  initial begin
    $display("[TB] rv_fetch_bridge directed bench start");
    test_reset();
    test_basic_fetch();
    test_delayed_gnt();
    test_flush_wait();
    test_flush_idle();
    test_timeout();
    test_misaligned();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatches);
    $finish;
  end

endmodule
